// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM read arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the current burst
package sdram_arb_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        GAP
    } state_t;

    typedef enum logic {
        OWN_VID,
        OWN_CPU
    } owner_t;

endpackage

// File: rtl/sdram_req_latch.sv
// Single-entry request latch: a pending flag plus the captured start address.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : one-cycle request pulse, captures addr_i
//   addr_i        : request address
//   grant_i       : arbiter grant; clears pending unless a new pulse arrives
//   pending_o     : a request is waiting to be granted
//   addr_o        : most recently captured address
module sdram_req_latch #(
    parameter int unsigned ADDR_W = sdram_arb_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              grant_i,
    output logic              pending_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic              pending_q;
    logic [ADDR_W-1:0] addr_q;

    // A new pulse always wins over the grant, so a request arriving in the
    // grant cycle stays pending. Repeated pulses only overwrite the address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            if (req_i) begin
                pending_q <= 1'b1;
                addr_q    <= addr_i;
            end else if (grant_i) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign pending_o = pending_q;
    assign addr_o    = addr_q;

endmodule

// File: rtl/sdram_read_arbiter.sv
// Shares the SDRAM read port between the video line-fetch path (bursts it
// ends itself) and the CPU/ROM path (single words).
//   clk_sys_99_287, reset_n : system clock, asynchronous active-low reset
//   vid_rd/vid_addr         : video burst request and start address
//   vid_end_burst           : video request to end its burst
//   vid_data_available/vid_data : video data path (combinational from sd_out)
//   cpu_rd/cpu_addr         : CPU single-word request and address
//   cpu_data/cpu_ack        : registered CPU word and one-cycle valid pulse
//   sd_rd/sd_rd_addr        : read pulse and address to the controller
//   sd_end_burst            : burst terminate to the controller
//   sd_data_available/sd_out: controller data strobe and data
//   timeout_err             : sticky, set when no data arrives in time
module sdram_read_arbiter #(
    parameter int unsigned ADDR_W       = sdram_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W       = sdram_arb_pkg::DATA_W,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic              clk_sys_99_287,
    input  logic              reset_n,
    input  logic              vid_rd,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_end_burst,
    output logic              vid_data_available,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_rd,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ack,
    output logic              sd_rd,
    output logic              sd_end_burst,
    output logic [ADDR_W-1:0] sd_rd_addr,
    input  logic              sd_data_available,
    input  logic [DATA_W-1:0] sd_out,
    output logic              timeout_err
);

    import sdram_arb_pkg::*;

    localparam int unsigned WaitW   = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WaitW-1:0]   WaitLast  = WaitW'(WAIT_TIMEOUT - 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    state_t              state_q;
    owner_t              owner_q;
    logic [WaitW-1:0]    wait_cnt_q;
    logic [StarveW-1:0]  starve_cnt_q;
    logic                sd_rd_q;
    logic [ADDR_W-1:0]   sd_rd_addr_q;
    logic [DATA_W-1:0]   cpu_data_q;
    logic                cpu_ack_q;
    logic                timeout_err_q;
    logic                data_prev_q;

    logic                vid_pending;
    logic                cpu_pending;
    logic [ADDR_W-1:0]   vid_addr_lat;
    logic [ADDR_W-1:0]   cpu_addr_lat;
    logic                cpu_wins;
    logic                cpu_grant;
    logic                vid_grant;
    logic                in_xfer;
    logic                cpu_first_word;

    sdram_req_latch #(
        .ADDR_W (ADDR_W)
    ) u_vid_latch (
        .clk_i     (clk_sys_99_287),
        .rst_ni    (reset_n),
        .req_i     (vid_rd),
        .addr_i    (vid_addr),
        .grant_i   (vid_grant),
        .pending_o (vid_pending),
        .addr_o    (vid_addr_lat)
    );

    sdram_req_latch #(
        .ADDR_W (ADDR_W)
    ) u_cpu_latch (
        .clk_i     (clk_sys_99_287),
        .rst_ni    (reset_n),
        .req_i     (cpu_rd),
        .addr_i    (cpu_addr),
        .grant_i   (cpu_grant),
        .pending_o (cpu_pending),
        .addr_o    (cpu_addr_lat)
    );

    // Video has priority, but a waiting CPU request takes the next slot once
    // video has won STARVE_LIMIT grants in a row against it.
    always_comb begin
        cpu_wins  = cpu_pending && (!vid_pending || (starve_cnt_q == StarveMax));
        cpu_grant = (state_q == IDLE) && cpu_wins;
        vid_grant = (state_q == IDLE) && vid_pending && !cpu_wins;
    end

    assign in_xfer        = (state_q == WAIT) || (state_q == BURST);
    assign cpu_first_word = sd_data_available && (state_q == WAIT) && (owner_q == OWN_CPU);

    // Zero-latency steering; strobes outside WAIT/BURST are dropped.
    assign vid_data_available = sd_data_available && in_xfer && (owner_q == OWN_VID);
    assign vid_data           = sd_out;

    always_comb begin
        sd_end_burst = 1'b0;
        if (in_xfer) begin
            if (owner_q == OWN_VID) begin
                sd_end_burst = vid_end_burst;
            end else begin
                sd_end_burst = cpu_first_word;
            end
        end
    end

    always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= OWN_VID;
            wait_cnt_q    <= '0;
            starve_cnt_q  <= '0;
            sd_rd_q       <= 1'b0;
            sd_rd_addr_q  <= '0;
            cpu_data_q    <= '0;
            cpu_ack_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            data_prev_q   <= 1'b0;
        end else begin
            sd_rd_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            data_prev_q <= sd_data_available;

            if (!cpu_pending || cpu_grant) begin
                starve_cnt_q <= '0;
            end else if (vid_grant && (starve_cnt_q != StarveMax)) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (cpu_grant || vid_grant) begin
                        sd_rd_q    <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= WAIT;
                        if (cpu_grant) begin
                            owner_q      <= OWN_CPU;
                            sd_rd_addr_q <= cpu_addr_lat;
                        end else begin
                            owner_q      <= OWN_VID;
                            sd_rd_addr_q <= vid_addr_lat;
                        end
                    end
                end
                WAIT: begin
                    if (sd_data_available) begin
                        state_q <= BURST;
                        if (owner_q == OWN_CPU) begin
                            cpu_data_q <= sd_out;
                            cpu_ack_q  <= 1'b1;
                        end
                    end else if (wait_cnt_q == WaitLast) begin
                        // Controller never answered: drop the request.
                        state_q       <= IDLE;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                BURST: begin
                    if (data_prev_q && !sd_data_available) begin
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    // One idle cycle so the controller settles before the next grant.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sd_rd       = sd_rd_q;
    assign sd_rd_addr  = sd_rd_addr_q;
    assign cpu_data    = cpu_data_q;
    assign cpu_ack     = cpu_ack_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Scoreboard bench for sdram_read_arbiter: directed stimulus pushes expected
// grant addresses and data words; a negedge monitor pops and compares.
module tb_sdram_read_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vid_rd;
    logic [AW-1:0] vid_addr;
    logic          vid_end_burst;
    logic          vid_data_available;
    logic [DW-1:0] vid_data;
    logic          cpu_rd;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_ack;
    logic          sd_rd;
    logic          sd_end_burst;
    logic [AW-1:0] sd_rd_addr;
    logic          sd_data_available;
    logic [DW-1:0] sd_out;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_vid_q[$];
    logic [DW-1:0] exp_cpu_q[$];

    always #5 clk = ~clk;

    sdram_read_arbiter dut (
        .clk_sys_99_287     (clk),
        .reset_n            (reset_n),
        .vid_rd             (vid_rd),
        .vid_addr           (vid_addr),
        .vid_end_burst      (vid_end_burst),
        .vid_data_available (vid_data_available),
        .vid_data           (vid_data),
        .cpu_rd             (cpu_rd),
        .cpu_addr           (cpu_addr),
        .cpu_data           (cpu_data),
        .cpu_ack            (cpu_ack),
        .sd_rd              (sd_rd),
        .sd_end_burst       (sd_end_burst),
        .sd_rd_addr         (sd_rd_addr),
        .sd_data_available  (sd_data_available),
        .sd_out             (sd_out),
        .timeout_err        (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT-presented transaction is matched against the queues.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (sd_rd) begin
                if (exp_addr_q.size() == 0) check("sd_rd_unexpected", 32'(sd_rd), 32'd0);
                else check("sd_rd_addr", 32'(sd_rd_addr), 32'(exp_addr_q.pop_front()));
            end
            if (vid_data_available) begin
                if (exp_vid_q.size() == 0) check("vid_unexpected", 32'(vid_data_available), 32'd0);
                else check("vid_data", 32'(vid_data), 32'(exp_vid_q.pop_front()));
            end
            if (cpu_ack) begin
                if (exp_cpu_q.size() == 0) check("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
                else check("cpu_data", 32'(cpu_data), 32'(exp_cpu_q.pop_front()));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sd_rd(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sd_rd) break;
            tick();
        end
        check(name, 32'(sd_rd), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sd_rd"}, 32'(sd_rd), 32'd0);
        check({tag, "_sd_end_burst"}, 32'(sd_end_burst), 32'd0);
        check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        check({tag, "_sd_rd_addr"}, 32'(sd_rd_addr), 32'd0);
        check({tag, "_cpu_data"}, 32'(cpu_data), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_vid_strobe"}, 32'(vid_data_available), 32'd0);
    endtask

    // Controller model for a video-owned burst; ends in the data falling-edge cycle.
    task automatic serve_vid(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            tick();
            sd_data_available = 1'b1;
            sd_out            = base + DW'(i);
            vid_end_burst     = (i == n - 1);
            exp_vid_q.push_back(base + DW'(i));
            #1;
            if (i == n - 1) check("vid_end_burst_fwd", 32'(sd_end_burst), 32'd1);
            else if (i == 0) check("vid_no_early_end", 32'(sd_end_burst), 32'd0);
        end
        tick();
        sd_data_available = 1'b0;
        vid_end_burst     = 1'b0;
        #1;
        check("vid_strobe_drop", 32'(vid_data_available), 32'd0);
    endtask

    // Controller returns two words for a CPU read; only the first is kept.
    task automatic serve_cpu(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        tick();
        sd_data_available = 1'b1;
        sd_out            = w0;
        exp_cpu_q.push_back(w0);
        #1;
        check("cpu_end_first_word", 32'(sd_end_burst), 32'd1);
        check("cpu_no_vid_strobe0", 32'(vid_data_available), 32'd0);
        tick();
        sd_out = w1;
        #1;
        check("cpu_no_vid_strobe1", 32'(vid_data_available), 32'd0);
        check("cpu_end_only_first", 32'(sd_end_burst), 32'd0);
        check("cpu_ack_pulse", 32'(cpu_ack), 32'd1);
        tick();
        sd_data_available = 1'b0;
        #1;
        check("cpu_ack_single", 32'(cpu_ack), 32'd0);
        check("cpu_data_hold", 32'(cpu_data), 32'(w0));
    endtask

    initial begin
        reset_n           = 1'b0;
        vid_rd            = 1'b0;
        vid_addr          = '0;
        vid_end_burst     = 1'b0;
        cpu_rd            = 1'b0;
        cpu_addr          = '0;
        sd_data_available = 1'b0;
        sd_out            = '0;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick();

        // Video only, followed by a back-to-back request on the falling edge.
        vid_rd   = 1'b1;
        vid_addr = 25'h000100;
        exp_addr_q.push_back(25'h000100);
        tick();
        vid_rd = 1'b0;
        wait_sd_rd("vid_grant", 10);
        tick();
        check("sd_rd_one_cycle", 32'(sd_rd), 32'd0);
        serve_vid(8, 16'hA000);
        vid_rd   = 1'b1;
        vid_addr = 25'h000200;
        exp_addr_q.push_back(25'h000200);
        tick();
        vid_rd            = 1'b0;
        sd_data_available = 1'b1;  // stray strobe during GAP
        #1;
        check("gap_strobe_ignored", 32'(vid_data_available), 32'd0);
        check("b2b_sd_rd_gap", 32'(sd_rd), 32'd0);
        tick();
        sd_data_available = 1'b0;
        check("b2b_sd_rd_idle", 32'(sd_rd), 32'd0);
        tick();
        check("b2b_sd_rd_latency", 32'(sd_rd), 32'd1);
        serve_vid(2, 16'hB000);

        // CPU only.
        repeat (2) tick();
        cpu_rd   = 1'b1;
        cpu_addr = 25'h1ABCDE;
        exp_addr_q.push_back(25'h1ABCDE);
        tick();
        cpu_rd = 1'b0;
        wait_sd_rd("cpu_grant", 10);
        serve_cpu(16'h55AA, 16'h1234);

        // Simultaneous requests: video first, then CPU.
        repeat (2) tick();
        vid_rd   = 1'b1;
        vid_addr = 25'h000300;
        cpu_rd   = 1'b1;
        cpu_addr = 25'h000042;
        exp_addr_q.push_back(25'h000300);
        exp_addr_q.push_back(25'h000042);
        tick();
        vid_rd = 1'b0;
        cpu_rd = 1'b0;
        wait_sd_rd("simul_first_grant", 10);
        check("simul_vid_first", 32'(sd_rd_addr), 32'h300);
        serve_vid(3, 16'hE000);
        wait_sd_rd("simul_second_grant", 10);
        check("simul_cpu_second", 32'(sd_rd_addr), 32'h42);
        serve_cpu(16'hC0DE, 16'hFFFF);

        // Starvation: four video bursts, then the waiting CPU, then video again.
        repeat (2) tick();
        cpu_rd   = 1'b1;
        cpu_addr = 25'h000077;
        vid_rd   = 1'b1;
        vid_addr = 25'h000400;
        exp_addr_q.push_back(25'h000400);
        exp_addr_q.push_back(25'h000401);
        exp_addr_q.push_back(25'h000402);
        exp_addr_q.push_back(25'h000403);
        exp_addr_q.push_back(25'h000077);
        exp_addr_q.push_back(25'h000404);
        tick();
        cpu_rd = 1'b0;
        vid_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_sd_rd("starve_vid_grant", 10);
            check("starve_vid_addr", 32'(sd_rd_addr), 32'h400 + 32'(k));
            vid_rd   = 1'b1;
            vid_addr = AW'(32'h401 + 32'(k));
            tick();
            vid_rd = 1'b0;
            serve_vid(2, DW'(32'h2000 + 32'(k) * 16));
        end
        wait_sd_rd("starve_cpu_grant", 10);
        check("starve_cpu_addr", 32'(sd_rd_addr), 32'h77);
        serve_cpu(16'h9999, 16'h8888);
        wait_sd_rd("starve_vid_resume", 10);
        check("starve_vid_resume_addr", 32'(sd_rd_addr), 32'h404);
        serve_vid(1, 16'h3000);

        // Timeout: no data for 64 cycles after sd_rd.
        repeat (2) tick();
        vid_rd   = 1'b1;
        vid_addr = 25'h000500;
        exp_addr_q.push_back(25'h000500);
        tick();
        vid_rd = 1'b0;
        wait_sd_rd("to_grant", 10);
        repeat (63) tick();
        check("to_not_yet", 32'(timeout_err), 32'd0);
        tick();
        check("to_set", 32'(timeout_err), 32'd1);
        cpu_rd   = 1'b1;
        cpu_addr = 25'h1FFFFFF;
        exp_addr_q.push_back(25'h1FFFFFF);
        tick();
        cpu_rd = 1'b0;
        wait_sd_rd("to_cpu_grant", 10);
        serve_cpu(16'hBEEF, 16'h0BAD);
        check("to_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of a video burst.
        repeat (2) tick();
        vid_rd   = 1'b1;
        vid_addr = 25'h000600;
        exp_addr_q.push_back(25'h000600);
        tick();
        vid_rd = 1'b0;
        wait_sd_rd("mid_grant", 10);
        tick();
        sd_data_available = 1'b1;
        sd_out            = 16'hD000;
        exp_vid_q.push_back(16'hD000);
        tick();
        sd_out        = 16'hD001;
        vid_end_burst = 1'b1;
        reset_n       = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        vid_end_burst = 1'b0;
        reset_n       = 1'b1;  // strobe still high after release
        #1;
        check("post_rst_stray0", 32'(vid_data_available), 32'd0);
        tick();
        check("post_rst_stray1", 32'(vid_data_available), 32'd0);
        check("post_rst_no_rd", 32'(sd_rd), 32'd0);
        sd_data_available = 1'b0;
        repeat (2) tick();

        check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
        check("vid_q_drained", 32'(exp_vid_q.size()), 32'd0);
        check("cpu_q_drained", 32'(exp_cpu_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
